mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller between the EX_MEM pipeline register and MEM_WB. Turns the EX_MEM load/store control and address into a request/ready transaction on the data-memory port. It stalls the pipeline until the access completes, then formats load data with byte/half extraction and sign/zero extension for MEM_WB's MEMdata input. It also flags misaligned or illegal accesses and memory time-outs.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without mem_ready_i before abort (≥1, ≤255).
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- MemRead_i  in  1  load request from EX_MEM.
- MemWrite_i  in  1  store request from EX_MEM.
- funct3_i  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000 sb, 001 sh, 010 sw.
- addr_i  in  32  byte address (EX_MEM ALUresult).
- wdata_i  in  32  store data (EX_MEM rs2 data).
- MEMdata_o  out  32  formatted load data to MEM_WB MEMdata_i.
- stall_o  out  1  holds PC, IF_ID, ID_EX and EX_MEM.
- access_err_o  out  1  misaligned or illegal access this cycle.
- timeout_o  out  1  one-cycle pulse on memory time-out abort.
- mem_req_o  out  1  memory request valid.
- mem_we_o  out  1  1 = write.
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata_o  out  32  lane-replicated store data.
- mem_be_o  out  4  byte enables (bit n = byte lane n, little-endian).
- mem_ready_i  in  1  memory completes the request this cycle.
- mem_rdata_i  in  32  read word, valid when mem_ready_i=1 and mem_we_o=0.

## Operation
- States: IDLE, REQ, DONE.
- An op is valid when exactly one of MemRead_i and MemWrite_i is 1.
- Illegal access (checked in IDLE only):
  - both MemRead_i and MemWrite_i are 1;
  - load funct3 ∈ {011,110,111}, or store funct3 ∉ {000,001,010};
  - halfword with addr[0]=1, or word with addr[1:0]≠00.
  - Response: access_err_o=1 combinationally, no request, stall_o=0, MEMdata_o unchanged, state stays IDLE.
- IDLE, legal op:
  - stall_o=1 combinationally.
  - On the edge, register mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, funct3 and addr[1:0]; clear the timeout counter; go to REQ.
- Byte enables: sb → 0001<<addr[1:0]; sh → 0011<<addr[1:0]; sw → 1111.
- Store data: sb replicates wdata[7:0] ×4; sh replicates wdata[15:0] ×2; sw passes wdata through.
- REQ:
  - mem_req_o=1 and stall_o=1.
  - If mem_ready_i=1: for loads, capture the formatted rdata into MEMdata_o; go to DONE.
  - Else the counter increments; when it reaches TIMEOUT_CYCLES, drop the request, pulse timeout_o in the following cycle, set MEMdata_o=0, and go to DONE.
- Load format:
  - lb/lbu select byte lane addr[1:0]; lh/lhu select halfword addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Stores leave MEMdata_o unchanged.
- DONE:
  - mem_req_o=0, stall_o=0; the pipeline advances at this edge and MEM_WB captures MEMdata_o.
  - Inputs are not examined in DONE (no double issue); next state is IDLE.
  - MEMdata_o holds its value until the next load capture.

## Timing
- Reset values: state IDLE, MEMdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, timeout_o=0, counter=0.
- stall_o and access_err_o are 0 while rst_i=1.
- Reset mid-REQ: mem_req_o drops at that edge; no data capture.
- Latency: with mem_ready_i in the Nth REQ cycle (N≥1), stall_o is high for N+1 cycles and MEMdata_o is valid in DONE.
  - Minimum: 2 stall cycles plus 1 DONE cycle, i.e. an access occupies 3 cycles.
- Request fields stay constant for the whole of REQ.
- mem_ready_i is ignored outside REQ.
- Time-out: mem_req_o is high for exactly TIMEOUT_CYCLES cycles; timeout_o is high during DONE only.
- A mem_ready_i in the same cycle the counter reaches the limit counts as success.
- No op (neither read nor write): all outputs idle, stall_o=0.

## Test plan
- Reset: assert rst_i 2 cycles during a REQ → next cycle mem_req_o=0, MEMdata_o=0, stall_o=0, state IDLE.
- lw, addr 0x100, mem_ready_i in 3rd REQ cycle with rdata 0xDEADBEEF → stall_o high 4 cycles, mem_addr_o=0x100, mem_be_o=1111, MEMdata_o=0xDEADBEEF in DONE, stall_o=0 in DONE.
- lb, addr 0x103, rdata 0x80FFFFFF, ready in 1st REQ cycle → MEMdata_o=0xFFFFFF80; repeat as lbu → 0x00000080; lhu at 0x102 → 0x000080FF.
- sh, addr 0x102, wdata 0x1234ABCD → mem_we_o=1, mem_be_o=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x100, MEMdata_o unchanged.
- lw at 0x101, and MemRead_i=MemWrite_i=1 at 0x100 → access_err_o=1 same cycle, mem_req_o stays 0, stall_o=0.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 → mem_req_o high exactly 4 cycles, timeout_o pulses 1 cycle, MEMdata_o=0, then a back-to-back lw issues normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues EX_MEM loads/stores as request/ready
// transactions, stalls the pipeline meanwhile and formats load data for MEM_WB.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] MEMdata_o,
   output logic        stall_o,
   output logic        access_err_o,
   output logic        timeout_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_be_o,
   input  logic        mem_ready_i,
   input  logic [31:0] mem_rdata_i
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         f3_q;
   logic [1:0]         off_q;
   logic               op_valid, bad_f3, misaligned, illegal, legal_op;
   logic               timeout_hit;
   logic [3:0]         be_next;
   logic [31:0]        wdata_next;
   logic [7:0]         rd_byte;
   logic [15:0]        rd_half;
   logic [31:0]        load_fmt;

   // Request decode and legality, only meaningful while IDLE
   always_comb begin
      op_valid   = MemRead_i ^ MemWrite_i;
      bad_f3     = MemRead_i ? (funct3_i inside {3'b011, 3'b110, 3'b111})
                             : !(funct3_i inside {3'b000, 3'b001, 3'b010});
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      illegal    = (MemRead_i & MemWrite_i) | (op_valid & (bad_f3 | misaligned));
      legal_op   = op_valid & ~illegal;
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_next    = 4'b0001 << addr_i[1:0];
            wdata_next = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_next    = 4'b0011 << addr_i[1:0];
            wdata_next = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction and extension of the returned read word
   always_comb begin
      rd_byte  = mem_rdata_i[7:0];
      case (off_q)
         2'd1:    rd_byte = mem_rdata_i[15:8];
         2'd2:    rd_byte = mem_rdata_i[23:16];
         2'd3:    rd_byte = mem_rdata_i[31:24];
         default: rd_byte = mem_rdata_i[7:0];
      endcase
      rd_half  = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      load_fmt = mem_rdata_i;
      case (f3_q)
         3'b000:  load_fmt = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_fmt = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_fmt = {24'd0, rd_byte};
         3'b101:  load_fmt = {16'd0, rd_half};
         default: load_fmt = mem_rdata_i;
      endcase
   end

   // A ready in the final counted cycle wins over the time-out
   assign timeout_hit = (state == REQ) && !mem_ready_i &&
                        (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (legal_op) state_next = REQ;
         REQ:     if (mem_ready_i || timeout_hit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      stall_o      = 1'b0;
      access_err_o = 1'b0;
      mem_req_o    = 1'b0;
      case (state)
         IDLE: begin
            stall_o      = legal_op & ~rst_i;
            access_err_o = illegal & ~rst_i;
         end
         REQ: begin
            stall_o   = ~rst_i;
            mem_req_o = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         MEMdata_o   <= '0;
         timeout_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_be_o    <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         cnt         <= '0;
      end else begin
         timeout_o <= timeout_hit;
         case (state)
            IDLE: if (legal_op) begin
               mem_we_o    <= MemWrite_i;
               mem_addr_o  <= {addr_i[31:2], 2'b00};
               mem_be_o    <= be_next;
               mem_wdata_o <= wdata_next;
               f3_q        <= funct3_i;
               off_q       <= addr_i[1:0];
               cnt         <= '0;
            end
            REQ: begin
               if (mem_ready_i) begin
                  if (!mem_we_o) MEMdata_o <= load_fmt;
               end else begin
                  cnt <= cnt + CNT_W'(1);
                  if (timeout_hit) MEMdata_o <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
